// File: rtl/aes_pkg.sv
// Shared AES constants and helpers.
//   KEY_128/KEY_192/KEY_256 : key_len encodings
//   ks_state_t              : key-schedule FSM states
//   nk_of / nr_of           : key words / rounds for a key_len
//   xtime                   : multiply by x in GF(2^8)
//   sbox                    : AES forward S-box
package aes_pkg;

  localparam logic [1:0] KEY_128 = 2'b00;
  localparam logic [1:0] KEY_192 = 2'b01;
  localparam logic [1:0] KEY_256 = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Bus between the key-schedule engine and its controller / round datapath.
//   start, key_len, key_in : expansion request (controller -> engine)
//   busy, done, err        : run status
//   rk_valid, rk_index, rk_data : round-key stream, one pulse per key
//   rd_addr / rd_data      : round-key buffer read port, 1-cycle latency
interface aes_key_schedule_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [127:0] rk_data;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  modport master (
    output start, key_len, key_in, rd_addr,
    input  busy, done, err, rk_valid, rk_index, rk_data, rd_data
  );

  modport slave (
    input  start, key_len, key_in, rd_addr,
    output busy, done, err, rk_valid, rk_index, rk_data, rd_data
  );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
//   i_word : input word
//   o_word : byte-wise S-box substitution of i_word (combinational)
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion. One schedule word per clock
// into an 8-word sliding window; every fourth word completes a round key,
// which is streamed out (rk_valid/rk_index/rk_data) and written into a
// round-key buffer readable through rd_addr/rd_data (1-cycle latency).
//   clk, reset : clock, synchronous active-high reset
//   bus        : aes_key_schedule_if.slave (request, status, stream, read port)
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter bit          ENABLE_192 = 1'b1,
  parameter bit          ENABLE_256 = 1'b1,
  parameter int unsigned RK_DEPTH   = 15
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_schedule_if.slave  bus
);

  ks_state_t    r_state;
  logic [255:0] r_key;
  logic [3:0]   r_nk;
  logic [5:0]   r_c;
  logic [5:0]   r_last;
  logic [2:0]   r_j;
  logic [7:0]   r_rcon;
  logic [31:0]  r_win [8];
  logic [95:0]  r_acc;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic         r_rk_valid;
  logic [3:0]   r_rk_index;
  logic [127:0] r_rk_data;
  logic [127:0] r_rd_data;
  logic [127:0] r_buf [RK_DEPTH];

  logic         w_mode_ok;
  logic         w_key_phase;
  logic         w_j_last;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_word;
  logic [127:0] w_rk;
  logic         w_rk_wr;

  always_comb begin
    w_mode_ok = (bus.key_len == KEY_128) ||
                ((bus.key_len == KEY_192) && ENABLE_192) ||
                ((bus.key_len == KEY_256) && ENABLE_256);
  end

  // r_win[0] is w[c-1]; r_win[k-1] is w[c-k], so w[c-Nk] sits at Nk-1.
  assign w_prev      = r_win[0];
  assign w_back      = r_win[3'(r_nk - 4'd1)];
  assign w_key_phase = (r_c < {2'b00, r_nk});
  assign w_j_last    = (r_j == 3'(r_nk - 4'd1));

  // One S-box bank serves both RotWord (j==0) and the AES-256 j==4 step.
  assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_word = w_back ^ w_prev;
    if (w_key_phase) begin
      w_word = r_key[255:224];
    end else if (r_j == 3'd0) begin
      w_word = w_back ^ w_sub_out ^ {r_rcon, 24'h0};
    end else if ((r_nk == 4'd8) && (r_j == 3'd4)) begin
      w_word = w_back ^ w_sub_out;
    end
  end

  assign w_rk    = {r_acc, w_word};
  assign w_rk_wr = (r_state == S_EXPAND) && (r_c[1:0] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_nk       <= 4'd4;
      r_c        <= '0;
      r_last     <= '0;
      r_j        <= '0;
      r_rcon     <= 8'h01;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_index <= '0;
      r_rk_data  <= '0;
      for (int unsigned k = 0; k < 8; k++) begin
        r_win[k] <= '0;
      end
    end else begin
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_mode_ok) begin
              r_key   <= bus.key_in;
              r_nk    <= nk_of(bus.key_len);
              r_last  <= {nr_of(bus.key_len), 2'b11};
              r_c     <= '0;
              r_j     <= '0;
              r_rcon  <= 8'h01;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_EXPAND;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_EXPAND: begin
          // Key words are consumed from the top, so shift the copy left.
          r_key    <= r_key << 32;
          r_win[0] <= w_word;
          for (int unsigned k = 1; k < 8; k++) begin
            r_win[k] <= r_win[k-1];
          end
          r_acc <= w_rk[95:0];
          r_c   <= r_c + 6'd1;
          r_j   <= w_j_last ? 3'd0 : r_j + 3'd1;
          if (!w_key_phase && (r_j == 3'd0)) begin
            r_rcon <= xtime(r_rcon);
          end
          if (r_c[1:0] == 2'b11) begin
            r_rk_valid <= 1'b1;
            r_rk_index <= r_c[5:2];
            r_rk_data  <= w_rk;
          end
          if (r_c == r_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && w_rk_wr && (32'(r_c[5:2]) < RK_DEPTH)) begin
      r_buf[r_c[5:2]] <= w_rk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (32'(bus.rd_addr) < RK_DEPTH) begin
      r_rd_data <= r_buf[bus.rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.rk_valid = r_rk_valid;
  assign bus.rk_index = r_rk_index;
  assign bus.rk_data  = r_rk_data;
  assign bus.rd_data  = r_rd_data;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_schedule_if bus ();
  aes_key_schedule_if bus2 ();

  aes_key_schedule #(.ENABLE_192(1'b1), .ENABLE_256(1'b1), .RK_DEPTH(15)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  aes_key_schedule #(.ENABLE_192(1'b1), .ENABLE_256(1'b0), .RK_DEPTH(15)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    int           idx;
    logic [127:0] data;
    int           when;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_rk = 0;
  int           n_err = 0;
  logic [127:0] got_rk [16];
  logic [127:0] mkeys [16];
  logic [7:0]   sb [256];
  logic [7:0]   rc_tab [16];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t = {b, b} << k;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ rotl8(inv, k);
      sb[x] = s;
    end
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int i = 2; i < 16; i++) rc_tab[i] = gmul(rc_tab[i-1], 8'h02);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_run(input logic [255:0] key, input int nk, input int t0);
    logic [31:0] w [60];
    logic [31:0] t;
    exp_t        e;
    int          nr = nk + 6;
    int          nw = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = 32'(key >> (32 * (7 - i)));
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_tab[i/nk], 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx  = r;
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.when = t0 + 4 * r + 5;
      mkeys[r] = e.data;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (bus.err) n_err++;
    if (bus.rk_valid) begin
      n_rk++;
      got_rk[bus.rk_index] = bus.rk_data;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rk_unexpected: got idx %0d data %h at cycle %0d, want no pulse",
                 bus.rk_index, bus.rk_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (32'(bus.rk_index) != e.idx || bus.rk_data !== e.data || cyc != e.when) begin
          n_bad++;
          $display("FAIL rk_stream: got idx %0d data %h cycle %0d, want idx %0d data %h cycle %0d",
                   bus.rk_index, bus.rk_data, cyc, e.idx, e.data, e.when);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int nk_for(input logic [1:0] kl);
    return (kl == KEY_128) ? 4 : (kl == KEY_192) ? 6 : 8;
  endfunction

  // Returns at the negedge where done is first seen (or after the bound).
  task automatic wait_done(input int t0, input int nw, input string nm);
    int dc = -1;
    for (int k = 0; k < nw + 20; k++) begin
      @(negedge clk);
      if (cyc == t0 + nw) chk({nm, "_busy_last_word"}, 256'(bus.busy), 256'(1));
      if (bus.done) begin
        dc = cyc;
        break;
      end
    end
    chk({nm, "_done_cycle"}, 256'(dc), 256'(t0 + nw + 1));
    chk({nm, "_busy_at_done"}, 256'(bus.busy), 256'(0));
  endtask

  task automatic run_key(input logic [255:0] key, input logic [1:0] kl, input string nm);
    int nk = nk_for(kl);
    int nw = 4 * (nk + 7);
    int t0;
    int snap;
    @(posedge clk);
    #1;
    t0 = cyc;
    snap = n_rk;
    bus.start = 1'b1;
    bus.key_len = kl;
    bus.key_in = key;
    model_run(key, nk, t0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(t0, nw, nm);
    @(negedge clk);
    chk({nm, "_pulse_count"}, 256'(n_rk - snap), 256'(nk + 7));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           t0;
    int           snap;
    int           serr;
    logic [255:0] k;
    logic [1:0]   kl;

    build_tables();
    bus.start = 1'b0;  bus.key_len = 2'b00;  bus.key_in = '0;  bus.rd_addr = 4'd0;
    bus2.start = 1'b0; bus2.key_len = 2'b00; bus2.key_in = '0; bus2.rd_addr = 4'd0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_err", 256'(bus.err), 256'(0));
    chk("rst_rk_valid", 256'(bus.rk_valid), 256'(0));
    chk("rst_rk_index", 256'(bus.rk_index), 256'(0));
    chk("rst_rk_data", 256'(bus.rk_data), 256'(0));
    chk("rst_rd_data", 256'(bus.rd_data), 256'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    run_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, KEY_128, "aes128");
    chk("aes128_round1", 256'(got_rk[1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
    chk("aes128_round10", 256'(got_rk[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    run_key({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, KEY_192, "aes192");
    chk("aes192_round12", 256'(got_rk[12]), 256'(128'he98ba06f448c773c8ecc720401002202));

    run_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, KEY_256, "aes256");
    chk("aes256_round14", 256'(got_rk[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));

    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rd_addr_%0d", a), 256'(bus.rd_data), (a < 15) ? 256'(mkeys[a]) : 256'(0));
      if (a < 15) chk($sformatf("rd_vs_stream_%0d", a), 256'(bus.rd_data), 256'(got_rk[a]));
    end

    // Invalid mode: one err pulse, stays idle, done kept from the previous run.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.key_len = 2'b11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("inv_err_pulse", 256'(bus.err), 256'(1));
    chk("inv_busy", 256'(bus.busy), 256'(0));
    chk("inv_done_kept", 256'(bus.done), 256'(1));
    @(negedge clk);
    chk("inv_err_one_cycle", 256'(bus.err), 256'(0));
    chk("inv_busy_later", 256'(bus.busy), 256'(0));

    // AES-256 disabled instance.
    @(posedge clk);
    #1;
    bus2.start = 1'b1;
    bus2.key_len = KEY_256;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    @(negedge clk);
    chk("dis256_err", 256'(bus2.err), 256'(1));
    chk("dis256_busy", 256'(bus2.busy), 256'(0));
    @(posedge clk);
    #1;
    bus2.start = 1'b1;
    bus2.key_len = KEY_128;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    @(negedge clk);
    chk("dis256_128_accepted", 256'(bus2.busy), 256'(1));
    chk("dis256_128_no_err", 256'(bus2.err), 256'(0));

    // Reset in the middle of an AES-128 run.
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    @(posedge clk);
    #1;
    t0 = cyc;
    snap = n_rk;
    bus.start = 1'b1;
    bus.key_len = KEY_128;
    bus.key_in = k;
    model_run(k, 4, t0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_reset_cycle", 256'(cyc), 256'(t0 + 20));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", 256'(bus.busy), 256'(0));
    chk("mid_reset_done", 256'(bus.done), 256'(0));
    chk("mid_reset_pulses_before", 256'(n_rk - snap), 256'(4));
    exp_q.delete();
    snap = n_rk;
    repeat (70) @(negedge clk);
    chk("mid_reset_no_more_pulses", 256'(n_rk - snap), 256'(0));
    chk("mid_reset_stays_idle", 256'(bus.busy), 256'(0));
    run_key({$urandom, $urandom, $urandom, $urandom, 128'h0}, KEY_128, "after_reset");

    // Start held through a run: in-run start ignored, done-cycle start relaunches.
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    @(posedge clk);
    #1;
    t0 = cyc;
    snap = n_rk;
    serr = n_err;
    bus.start = 1'b1;
    bus.key_len = KEY_128;
    bus.key_in = k;
    model_run(k, 4, t0);
    model_run(k, 4, t0 + 45);
    @(posedge clk);
    #1;
    wait_done(t0, 44, "held1");
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("held_relaunch_busy", 256'(bus.busy), 256'(1));
    chk("held_relaunch_done_clr", 256'(bus.done), 256'(0));
    wait_done(t0 + 45, 44, "held2");
    repeat (2) @(negedge clk);
    chk("held_pulse_count", 256'(n_rk - snap), 256'(22));
    chk("held_no_err", 256'(n_err - serr), 256'(0));

    // Randomized runs over all modes.
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(0, 2));
      run_key(k, kl, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
